// File: rtl/vedic_mul_arbiter_ctrl.sv
// Round-robin arbiter and sequencer sharing one 2x2 Vedic multiplier between two requesters,
// with per-requester result registers and a 4-digit multiplexed seven-segment scan.
module vedic_mul_arbiter_ctrl #(
  parameter logic [15:0] SCAN_DIV = 16'd50000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       req0_i,
  input  logic       req1_i,
  input  logic [1:0] a0_i,
  input  logic [1:0] b0_i,
  input  logic [1:0] a1_i,
  input  logic [1:0] b1_i,
  output logic       ack0_o,
  output logic       ack1_o,
  output logic [3:0] q_out_o,
  output logic       grant_id_o,
  output logic [1:0] mul_a_o,
  output logic [1:0] mul_b_o,
  input  logic [3:0] mul_q_i,
  output logic [3:0] digit_o,
  output logic [3:0] anodes_o
);

  typedef enum logic [1:0] {IDLE, EXEC, ACK} state_e;

  state_e      state_q, state_d;
  logic        ack0_q, ack0_d, ack1_q, ack1_d;
  logic [3:0]  q_out_q, q_out_d;
  logic [1:0]  mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic        grant_q, grant_d, last_q, last_d;
  logic [3:0]  res0_q, res0_d, res1_q, res1_d;
  logic [15:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  anodes_q, anodes_d;
  logic        win;
  logic        scan_wrap;

  always_comb begin
    state_d = state_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    q_out_d = q_out_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    grant_d = grant_q;
    last_d  = last_q;
    res0_d  = res0_q;
    res1_d  = res1_q;
    win     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req0_i || req1_i) begin
          // On a tie the requester that was not served last wins.
          win     = (req0_i && req1_i) ? ~last_q : req1_i;
          mul_a_d = win ? a1_i : a0_i;
          mul_b_d = win ? b1_i : b0_i;
          grant_d = win;
          last_d  = win;
          state_d = EXEC;
        end
      end
      EXEC: begin
        q_out_d = mul_q_i;
        if (grant_q) res1_d = mul_q_i;
        else         res0_d = mul_q_i;
        ack0_d  = ~grant_q;
        ack1_d  = grant_q;
        state_d = ACK;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Scan runs free of the arbiter; anodes are precomputed from the next index.
  always_comb begin
    scan_wrap  = (scan_cnt_q == SCAN_DIV - 16'd1);
    scan_cnt_d = scan_wrap ? 16'd0 : scan_cnt_q + 16'd1;
    idx_d      = scan_wrap ? idx_q + 2'd1 : idx_q;
    anodes_d   = ~(4'b0001 << idx_d);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      q_out_q    <= 4'd0;
      mul_a_q    <= 2'd0;
      mul_b_q    <= 2'd0;
      grant_q    <= 1'b0;
      last_q     <= 1'b1;
      res0_q     <= 4'd0;
      res1_q     <= 4'd0;
      scan_cnt_q <= 16'd0;
      idx_q      <= 2'd0;
      anodes_q   <= 4'b1110;
    end else begin
      state_q    <= state_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      q_out_q    <= q_out_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      res0_q     <= res0_d;
      res1_q     <= res1_d;
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      anodes_q   <= anodes_d;
    end
  end

  always_comb begin
    digit_o = 4'd0;
    unique case (idx_q)
      2'd0:    digit_o = res0_q;
      2'd1:    digit_o = res1_q;
      2'd2:    digit_o = {mul_a_q, mul_b_q};
      default: digit_o = {3'b000, grant_q};
    endcase
  end

  assign ack0_o     = ack0_q;
  assign ack1_o     = ack1_q;
  assign q_out_o    = q_out_q;
  assign grant_id_o = grant_q;
  assign mul_a_o    = mul_a_q;
  assign mul_b_o    = mul_b_q;
  assign anodes_o   = anodes_q;

endmodule

// File: tb/tb_vedic_mul_arbiter_ctrl.sv
// Scoreboard bench for vedic_mul_arbiter_ctrl: the bench models the external multiplier,
// queues expected products per grant and pops them on every ack pulse.
module tb_vedic_mul_arbiter_ctrl;

  typedef struct packed {
    logic       id;
    logic [3:0] q;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic       ack0, ack1, grant_id;
  logic [3:0] q_out, mul_q, digit, anodes;
  logic [1:0] mul_a, mul_b;

  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  exp_t sb[$];
  logic [3:0] res0_m = '0, res1_m = '0;

  always #5 clk = ~clk;

  // External shared multiplier
  assign mul_q = {2'b00, mul_a} * {2'b00, mul_b};

  vedic_mul_arbiter_ctrl #(.SCAN_DIV(16'd4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req0_i(req0), .req1_i(req1),
    .a0_i(a0), .b0_i(b0), .a1_i(a1), .b1_i(b1),
    .ack0_o(ack0), .ack1_o(ack1),
    .q_out_o(q_out), .grant_id_o(grant_id),
    .mul_a_o(mul_a), .mul_b_o(mul_b), .mul_q_i(mul_q),
    .digit_o(digit), .anodes_o(anodes)
  );

  // Pops the scoreboard on each ack and checks the result digits against the model.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (ack0 === 1'b1 || ack1 === 1'b1) begin
        checks++;
        if (ack0 === 1'b1 && ack1 === 1'b1) begin
          errors++;
          $display("[TB] FAIL dual_ack ack0=%0b ack1=%0b expected one-hot", ack0, ack1);
        end else if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_ack ack0=%0b ack1=%0b expected none", ack0, ack1);
        end else begin
          e = sb.pop_front();
          if ({ack1, q_out} !== {e.id, e.q}) begin
            errors++;
            $display("[TB] FAIL sb_ack got id=%0d q=%0d expected id=%0d q=%0d", ack1, q_out, e.id, e.q);
          end
          if (e.id) res1_m = e.q;
          else      res0_m = e.q;
        end
      end
      if (anodes === 4'b1110) begin
        checks++;
        if (digit !== res0_m) begin
          errors++;
          $display("[TB] FAIL digit_res0 got %0d expected %0d", digit, res0_m);
        end
      end else if (anodes === 4'b1101) begin
        checks++;
        if (digit !== res1_m) begin
          errors++;
          $display("[TB] FAIL digit_res1 got %0d expected %0d", digit, res1_m);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    res0_m = '0; res1_m = '0;
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic wait_ack(input bit which, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if ((which ? ack1 : ack0) === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    checks++;
    if ({ack0, ack1, q_out, mul_a, mul_b, grant_id} !== 14'd0) begin
      errors++;
      $display("[TB] FAIL reset_regs got ack0=%0b ack1=%0b q=%0d a=%0d b=%0d g=%0b expected all 0",
               ack0, ack1, q_out, mul_a, mul_b, grant_id);
    end
    checks++;
    if (anodes !== 4'b1110 || digit !== 4'd0) begin
      errors++;
      $display("[TB] FAIL reset_display got anodes=%b digit=%0d expected 1110/0", anodes, digit);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    req0 = 1'b1; a0 = 2'd3; b0 = 2'd3;
    sb.push_back('{id: 1'b0, q: 4'd9});
    @(negedge clk);
    checks++;
    if (mul_a !== 2'd3 || mul_b !== 2'd3 || grant_id !== 1'b0 || ack0 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_grant got a=%0d b=%0d g=%0b ack0=%0b expected 3/3/0/0",
               mul_a, mul_b, grant_id, ack0);
    end
    @(negedge clk);
    checks++;
    if (ack0 !== 1'b1 || ack1 !== 1'b0 || q_out !== 4'd9) begin
      errors++;
      $display("[TB] FAIL single_ack got ack0=%0b ack1=%0b q=%0d expected 1/0/9", ack0, ack1, q_out);
    end
    req0 = 1'b0;
    @(negedge clk);
    checks++;
    if (ack0 !== 1'b0 || q_out !== 4'd9) begin
      errors++;
      $display("[TB] FAIL single_hold got ack0=%0b q=%0d expected 0/9", ack0, q_out);
    end
  endtask

  task automatic test_tie();
    bit seen;
    int n;
    do_reset();
    req0 = 1'b1; a0 = 2'd2; b0 = 2'd3;
    req1 = 1'b1; a1 = 2'd1; b1 = 2'd3;
    sb.push_back('{id: 1'b0, q: 4'd6});
    sb.push_back('{id: 1'b1, q: 4'd3});
    wait_ack(1'b0, seen);
    checks++;
    if (!seen || q_out !== 4'd6) begin
      errors++;
      $display("[TB] FAIL tie_first got seen=%0b q=%0d expected 1/6", seen, q_out);
    end
    req0 = 1'b0;
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (ack1 === 1'b1) begin
        n = i;
        break;
      end
    end
    checks++;
    if (n != 3 || q_out !== 4'd3) begin
      errors++;
      $display("[TB] FAIL tie_second got spacing=%0d q=%0d expected 3/3", n, q_out);
    end
    req1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic e0, e1;
    do_reset();
    req0 = 1'b1; a0 = 2'd1; b0 = 2'd2;
    req1 = 1'b1; a1 = 2'd3; b1 = 2'd2;
    sb.push_back('{id: 1'b0, q: 4'd2});
    sb.push_back('{id: 1'b1, q: 4'd6});
    sb.push_back('{id: 1'b0, q: 4'd2});
    sb.push_back('{id: 1'b1, q: 4'd6});
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      e0 = (i == 1 || i == 7);
      e1 = (i == 4 || i == 10);
      checks++;
      if (ack0 !== e0 || ack1 !== e1) begin
        errors++;
        $display("[TB] FAIL contention_cycle%0d got ack0=%0b ack1=%0b expected %0b/%0b",
                 i, ack0, ack1, e0, e1);
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_exhaustive();
    bit seen;
    logic [3:0] p;
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        req1 = 1'b1;
        a1 = 2'(a);
        b1 = 2'(b);
        p = 4'(a * b);
        sb.push_back('{id: 1'b1, q: p});
        wait_ack(1'b1, seen);
        checks++;
        if (!seen || q_out !== p) begin
          errors++;
          $display("[TB] FAIL exh_%0dx%0d got seen=%0b q=%0d expected 1/%0d", a, b, seen, q_out, p);
        end
        req1 = 1'b0;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_display();
    bit seen, found;
    logic [3:0] prev;
    logic [3:0] an_tab[4];
    logic [3:0] dg_tab[4];
    int k;
    an_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    dg_tab = '{4'd6, 4'd0, 4'b1011, 4'd0};
    do_reset();
    req0 = 1'b1; a0 = 2'd2; b0 = 2'd3;
    sb.push_back('{id: 1'b0, q: 4'd6});
    wait_ack(1'b0, seen);
    req0 = 1'b0;
    checks++;
    if (!seen || q_out !== 4'd6) begin
      errors++;
      $display("[TB] FAIL disp_txn got seen=%0b q=%0d expected 1/6", seen, q_out);
    end
    found = 1'b0;
    prev  = anodes;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (prev == 4'b1110 && anodes == 4'b1101) begin
        found = 1'b1;
        break;
      end
      prev = anodes;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL disp_sync got anodes=%b expected 1110->1101 transition", anodes);
    end
    for (int j = 0; j < 16; j++) begin
      k = (1 + j / 4) % 4;
      checks++;
      if (anodes !== an_tab[k] || digit !== dg_tab[k]) begin
        errors++;
        $display("[TB] FAIL disp_cycle%0d got anodes=%b digit=%b expected %b/%b",
                 j, anodes, digit, an_tab[k], dg_tab[k]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_exec();
    bit seen, found;
    do_reset();
    req1 = 1'b1; a1 = 2'd3; b1 = 2'd3;
    sb.push_back('{id: 1'b1, q: 4'd9});
    wait_ack(1'b1, seen);
    req1 = 1'b0;
    @(negedge clk);
    req0 = 1'b1; a0 = 2'd3; b0 = 2'd3;
    @(negedge clk);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    checks++;
    if (ack0 !== 1'b0 || q_out !== 4'd0 || anodes !== 4'b1110 || digit !== 4'd0 || mul_a !== 2'd0) begin
      errors++;
      $display("[TB] FAIL mid_reset got ack0=%0b q=%0d anodes=%b digit=%0d a=%0d expected 0/0/1110/0/0",
               ack0, q_out, anodes, digit, mul_a);
    end
    req0 = 1'b0;
    res0_m = '0;
    res1_m = '0;
    sb.delete();
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    found  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (ack0 !== 1'b0 || ack1 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL mid_no_ack got ack0=%0b ack1=%0b expected 0/0", ack0, ack1);
      end
      if (anodes === 4'b1101) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found || digit !== 4'd0) begin
      errors++;
      $display("[TB] FAIL mid_res1_cleared got found=%0b digit=%0d expected 1/0", found, digit);
    end
    req0 = 1'b1; a0 = 2'd1; b0 = 2'd1;
    req1 = 1'b1; a1 = 2'd2; b1 = 2'd2;
    sb.push_back('{id: 1'b0, q: 4'd1});
    sb.push_back('{id: 1'b1, q: 4'd4});
    wait_ack(1'b0, seen);
    checks++;
    if (!seen || grant_id !== 1'b0 || q_out !== 4'd1) begin
      errors++;
      $display("[TB] FAIL mid_tie_first got seen=%0b g=%0b q=%0d expected 1/0/1", seen, grant_id, q_out);
    end
    req0 = 1'b0;
    wait_ack(1'b1, seen);
    checks++;
    if (!seen || q_out !== 4'd4) begin
      errors++;
      $display("[TB] FAIL mid_tie_second got seen=%0b q=%0d expected 1/4", seen, q_out);
    end
    req1 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t expected completion", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_back_to_back();
    test_exhaustive();
    test_display();
    test_reset_mid_exec();
    repeat (4) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL sb_drain got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
